// File: rtl/greeting_seg_sequencer.sv
// greeting_seg_sequencer
//   Steps through the greeting "MALIGAYANG PASKO" (16 characters, index 0..15)
//   and emits registered 7-segment codes, with a blank gap after every
//   character. The timebase is an internal prescaler.
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset (wins over everything)
//   en        in   1  global enable; 0 freezes all state and outputs
//   run       in   1  level; start / keep looping the message
//   speed     in   2  dwell = max(1, CHAR_TICKS >> speed), sampled on SHOW entry
//   seg       out  7  segment code {g,f,e,d,c,b,a}, 1 = lit
//   dp        out  1  decimal point, lit on the last character
//   char_idx  out  4  index of the current character
//   busy      out  1  high in any state except IDLE
//   done      out  1  one-cycle pulse in the final cycle of the last gap
module greeting_seg_sequencer #(
  parameter int unsigned TICK_DIV   = 12_000_000,
  parameter int unsigned CHAR_TICKS = 4,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       run,
  input  logic [1:0] speed,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] char_idx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMAX = (CHAR_TICKS > GAP_TICKS) ? CHAR_TICKS : GAP_TICKS;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state,    state_n;
  logic [3:0]    idx_n;
  logic [PW-1:0] presc,    presc_n;
  logic [TW-1:0] tick_cnt, tick_cnt_n;
  logic [TW-1:0] dwell,    dwell_n;
  logic          tick;
  logic [6:0]    seg_n;
  logic          dp_n, busy_n, done_n;

  function automatic logic [TW-1:0] dwell_of(input logic [1:0] spd);
    logic [TW-1:0] d;
    d = TW'(CHAR_TICKS >> spd);
    if (d == '0) d = TW'(1);
    return d;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] i);
    logic [6:0] g;
    case (i)
      4'd0:    g = 7'h37; // M
      4'd1:    g = 7'h77; // A
      4'd2:    g = 7'h38; // L
      4'd3:    g = 7'h06; // I
      4'd4:    g = 7'h3D; // G
      4'd5:    g = 7'h77; // A
      4'd6:    g = 7'h6E; // Y
      4'd7:    g = 7'h77; // A
      4'd8:    g = 7'h54; // N
      4'd9:    g = 7'h3D; // G
      4'd10:   g = 7'h00; // space
      4'd11:   g = 7'h73; // P
      4'd12:   g = 7'h77; // A
      4'd13:   g = 7'h6D; // S
      4'd14:   g = 7'h75; // K
      default: g = 7'h3F; // O
    endcase
    return g;
  endfunction

  assign tick = (presc == PRESC_LAST);

  always_comb begin
    state_n    = state;
    idx_n      = char_idx;
    presc_n    = presc;
    tick_cnt_n = tick_cnt;
    dwell_n    = dwell;
    case (state)
      S_IDLE: begin
        presc_n    = '0;
        tick_cnt_n = '0;
        if (run) begin
          state_n = S_SHOW;
          idx_n   = '0;
          dwell_n = dwell_of(speed);
        end
      end
      S_SHOW: begin
        presc_n = tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (tick_cnt == dwell - TW'(1)) begin
            state_n    = S_GAP;
            tick_cnt_n = '0;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      S_GAP: begin
        presc_n = tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (tick_cnt == GAP_LAST) begin
            tick_cnt_n = '0;
            if (char_idx != 4'hF) begin
              state_n = S_SHOW;
              idx_n   = char_idx + 4'd1;
              dwell_n = dwell_of(speed);
            end else begin
              idx_n = '0;
              if (run) begin
                state_n = S_SHOW;
                dwell_n = dwell_of(speed);
              end else begin
                state_n = S_IDLE;
              end
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      default: begin
        state_n    = S_IDLE;
        idx_n      = '0;
        presc_n    = '0;
        tick_cnt_n = '0;
      end
    endcase
  end

  // Outputs are registered copies of functions of the next state, so they
  // line up with the state they describe. done is high during the last
  // cycle of the final gap, i.e. when the next state is that cycle.
  always_comb begin
    seg_n  = (state_n == S_SHOW) ? glyph(idx_n) : 7'h00;
    dp_n   = (state_n == S_SHOW) && (idx_n == 4'hF);
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_GAP) && (idx_n == 4'hF) &&
             (tick_cnt_n == GAP_LAST) && (presc_n == PRESC_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      char_idx <= '0;
      presc    <= '0;
      tick_cnt <= '0;
      dwell    <= '0;
      seg      <= '0;
      dp       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (en) begin
      state    <= state_n;
      char_idx <= idx_n;
      presc    <= presc_n;
      tick_cnt <= tick_cnt_n;
      dwell    <= dwell_n;
      seg      <= seg_n;
      dp       <= dp_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_greeting_seg_sequencer.sv
// Scoreboard bench for greeting_seg_sequencer: a cycle-level behavioural
// model (phase + remaining-cycle countdown) pushes the expected outputs for
// every clock edge; a monitor pops and compares after each edge.
module tb_greeting_seg_sequencer;

  localparam int TD = 4;
  localparam int CT = 2;
  localparam int GT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       run = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] char_idx;
  logic       busy;
  logic       done;

  greeting_seg_sequencer #(
    .TICK_DIV  (TD),
    .CHAR_TICKS(CT),
    .GAP_TICKS (GT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .run     (run),
    .speed   (speed),
    .seg     (seg),
    .dp      (dp),
    .char_idx(char_idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    done_seen = 0;
  int    cyc = 0;

  // Model: 0 = idle, 1 = showing a character, 2 = blank gap
  int    m_phase = 0;
  int    m_rem = 0;
  int    m_idx = 0;
  string msg = "MALIGAYANG PASKO";

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "M": return 7'h37;
      "A": return 7'h77;
      "L": return 7'h38;
      "I": return 7'h06;
      "G": return 7'h3D;
      "Y": return 7'h6E;
      "N": return 7'h54;
      "P": return 7'h73;
      "S": return 7'h6D;
      "K": return 7'h75;
      "O": return 7'h3F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int show_cycles(input logic [1:0] spd);
    int d;
    d = CT >> spd;
    if (d < 1) d = 1;
    return d * TD;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.seg  = (m_phase == 1) ? glyph(msg[m_idx]) : 7'h00;
    o.dp   = (m_phase == 1) && (m_idx == 15);
    o.idx  = 4'(m_idx);
    o.busy = (m_phase != 0);
    o.done = (m_phase == 2) && (m_idx == 15) && (m_rem == 1);
    return o;
  endfunction

  task automatic step(input logic r, input logic e, input logic ru, input logic [1:0] sp);
    @(negedge clk);
    rst = r; en = e; run = ru; speed = sp;
    if (r) begin
      m_phase = 0; m_rem = 0; m_idx = 0;
    end else if (e) begin
      case (m_phase)
        0: if (ru) begin
             m_phase = 1; m_idx = 0; m_rem = show_cycles(sp);
           end
        1: begin
             m_rem--;
             if (m_rem == 0) begin
               m_phase = 2; m_rem = GT * TD;
             end
           end
        default: begin
             m_rem--;
             if (m_rem == 0) begin
               if (m_idx < 15) begin
                 m_idx++; m_phase = 1; m_rem = show_cycles(sp);
               end else begin
                 m_idx = 0;
                 if (ru) begin
                   m_phase = 1; m_rem = show_cycles(sp);
                 end else begin
                   m_phase = 0;
                 end
               end
             end
           end
      endcase
    end
    exp_q.push_back(model_out());
  endtask

  // Monitor
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{seg: seg, dp: dp, idx: char_idx, busy: busy, done: done};
        total++;
        if (a.done === 1'b1) done_seen++;
        if (a !== e)
          begin
            bad++;
            $display("FAIL outputs cyc=%0d: got seg=%h dp=%b idx=%0d busy=%b done=%b, want seg=%h dp=%b idx=%0d busy=%b done=%b",
                     cyc, a.seg, a.dp, a.idx, a.busy, a.done, e.seg, e.dp, e.idx, e.busy, e.done);
          end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r_run;
    // Reset
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    // Idle without run
    repeat (3) step(0, 1, 0, 0);
    // Continuous looping at speed 0: two full messages plus a bit
    repeat (400) step(0, 1, 1, 0);
    // Fastest dwell
    repeat (200) step(0, 1, 1, 3);
    // Drop run at idx 5; message must finish then idle
    for (int i = 0; i < 400 && m_idx != 5; i++) step(0, 1, 1, 3);
    for (int i = 0; i < 600 && m_phase != 0; i++) step(0, 1, 0, 1);
    repeat (5) step(0, 1, 0, 1);
    // Freeze mid-SHOW
    step(0, 1, 1, 0);
    repeat (3) step(0, 1, 1, 0);
    repeat (10) step(0, 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)));
    repeat (40) step(0, 1, 1, 0);
    // Reset mid-GAP
    for (int i = 0; i < 100 && m_phase != 2; i++) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    repeat (4) step(0, 1, 0, 0);
    // Randomised traffic
    r_run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) r_run = ~r_run;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), r_run,
           2'($urandom_range(0, 3)));
    end
    repeat (3) step(0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
    end
    total++;
    if (done_seen == 0) begin
      bad++;
      $display("FAIL done_seen: got %0d pulses, want at least 1", done_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
